steer_en: RTL and testbench
===========================

Name: steer_en

Overview:
- Rider-presence and steering-enable controller, directly downstream of the A2D interface.
- Consumes the left and right load-cell readings (12-bit, refreshed round-robin by the A2D interface) and decides whether a rider is on the platform.
- Asserts en_steer only after the rider has stood balanced for a qualification period.
- Its outputs gate the balance/steering controller and the motor drive.

Parameters:
- FAST_SIM, 0: 1 selects a 15-bit qualification timer for simulation; 0 selects a 26-bit timer (about 1.34 s at 50 MHz).
- MIN_RIDER_WT, 12'h200: minimum lft_ld+rght_ld sum treated as a rider present.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lft_ld  in  12  left load-cell reading, unsigned, from the A2D interface
- rght_ld  in  12  right load-cell reading, unsigned, from the A2D interface
- en_steer  out  1  registered; 1 = steering and balance permitted
- rider_off  out  1  registered; 1 = no rider detected (controller must zero integrator and drive)

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, timer=0, en_steer=0, rider_off=1.
- sum = lft_ld + rght_ld, computed as 13-bit unsigned with no overflow.
- diff = lft_ld - rght_ld, 13-bit signed. abs_diff = |diff|, 12-bit unsigned.
- sum_lt_min = (sum < MIN_RIDER_WT), after zero-extending MIN_RIDER_WT to 13 bits.
- diff_gt_1_4 = (abs_diff > sum>>2).
- diff_gt_15_16 = (abs_diff > sum - (sum>>4)).
- All comparisons are unsigned and combinational on the current inputs. No input registering is required, because the A2D outputs are already flopped.
- Timer:
  - Width TW = FAST_SIM ? 15 : 26.
  - tmr_full = all TW bits 1.
  - Counts up by 1 each cycle while in WAIT and not cleared.
  - Saturates at all-ones; never wraps.
  - Cleared synchronously by the state machine.
- State machine (Moore outputs, registered):
  - IDLE:
    - if !sum_lt_min -> WAIT, clear timer, rider_off<=0.
    - else stay, rider_off=1, en_steer=0.
  - WAIT:
    - if sum_lt_min -> IDLE, rider_off<=1, en_steer<=0 (takes priority).
    - else if diff_gt_1_4 -> stay, clear timer.
    - else if tmr_full -> STEER_EN, en_steer<=1.
    - else stay, timer increments.
  - STEER_EN:
    - if sum_lt_min -> IDLE, en_steer<=0, rider_off<=1 (takes priority).
    - else if diff_gt_15_16 -> WAIT, clear timer, en_steer<=0.
    - else stay, en_steer=1.
  - Unreachable encodings -> IDLE.
- Latency:
  - en_steer rises on the clock edge following the cycle in which tmr_full is seen in WAIT.
  - en_steer and rider_off respond one clock after the qualifying input condition.
- Boundary conditions:
  - sum == MIN_RIDER_WT counts as rider present.
  - abs_diff exactly equal to a threshold does not trip that threshold.
  - lft_ld = rght_ld = 12'hFFF: sum 13'h1FFE, no overflow.
  - A diff_gt_1_4 in WAIT at any time restarts the full qualification period.
- Reset mid-operation: any state -> IDLE immediately; outputs return to reset values asynchronously.
- en_steer and rider_off are never both 1.

Test Plan:
- Reset check (FAST_SIM=1): assert rst_n=0 with any loads -> en_steer=0, rider_off=1; hold lft=rght=0x080 (sum 0x100) for 40000 cycles -> stays IDLE, rider_off=1.
- Balanced qualification: lft=rght=0x180 (sum 0x300) -> rider_off=0 after 1 clk; en_steer rises exactly 32768 cycles later (±1 per the latency rule); check en_steer=0 at cycle 32000.
- Lean during WAIT: lft=0x250, rght=0x0B0 (abs_diff 0x1A0 > 0xC0) for 20000 cycles, then lft=rght=0x180 -> en_steer rises 32768 cycles after the balance point, not earlier.
- Step-off in STEER_EN:
  - lft=0x2F0, rght=0x010 (sum 0x300, abs_diff 0x2E0 > 0x2D0) -> en_steer=0 next clk, state WAIT, rider_off=0.
  - Then lft=rght=0x0F0 (sum 0x1E0) -> rider_off=1, state IDLE.
- Thresholds:
  - sum exactly 0x200 -> rider present.
  - abs_diff exactly sum>>2 -> timer keeps counting.
  - lft=rght=0xFFF -> no false trip, en_steer qualifies.
- Reset during STEER_EN: en_steer=1, pulse rst_n low mid-cycle -> en_steer=0 and rider_off=1 asynchronously; after release with balanced loads, full qualification period is required again.

Source files
------------

// File: rtl/steer_en.sv
// Rider-presence and steering-enable controller.
// Watches the left/right load cells, reports when nobody is on the platform,
// and only permits steering once the rider has stood balanced for a full
// qualification period.
module steer_en #(
    parameter bit          FAST_SIM     = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT = 12'h200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    // 15 bits gives a short qualification for simulation; 26 bits is ~1.34 s at 50 MHz.
    localparam int TW = FAST_SIM ? 15 : 26;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            en_steer_q, en_steer_d;
    logic            rider_off_q, rider_off_d;

    logic [12:0] sum;
    logic [11:0] abs_diff;
    logic [12:0] sum_15_16;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        tmr_full;

    // Load-cell arithmetic; A2D outputs are already flopped so no input stage.
    always_comb begin
        sum           = {1'b0, lft_ld} + {1'b0, rght_ld};
        abs_diff      = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
        sum_15_16     = sum - (sum >> 4);
        sum_lt_min    = sum < {1'b0, MIN_RIDER_WT};
        diff_gt_1_4   = {1'b0, abs_diff} > (sum >> 2);
        diff_gt_15_16 = {1'b0, abs_diff} > sum_15_16;
        tmr_full      = &tmr_q;
    end

    // Next-state, timer control and registered outputs.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        en_steer_d  = en_steer_q;
        rider_off_d = rider_off_q;
        unique case (state_q)
            IDLE: begin
                en_steer_d  = 1'b0;
                rider_off_d = 1'b1;
                if (!sum_lt_min) begin
                    state_d     = WAIT;
                    tmr_d       = '0;
                    rider_off_d = 1'b0;
                end
            end
            WAIT: begin
                en_steer_d  = 1'b0;
                rider_off_d = 1'b0;
                if (sum_lt_min) begin
                    state_d     = IDLE;
                    rider_off_d = 1'b1;
                end else if (diff_gt_1_4) begin
                    // Any lean restarts the whole qualification period.
                    tmr_d = '0;
                end else if (tmr_full) begin
                    state_d    = STEER_EN;
                    en_steer_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            STEER_EN: begin
                en_steer_d  = 1'b1;
                rider_off_d = 1'b0;
                if (sum_lt_min) begin
                    state_d     = IDLE;
                    en_steer_d  = 1'b0;
                    rider_off_d = 1'b1;
                end else if (diff_gt_15_16) begin
                    state_d    = WAIT;
                    tmr_d      = '0;
                    en_steer_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                tmr_d       = '0;
                en_steer_d  = 1'b0;
                rider_off_d = 1'b1;
            end
        endcase
    end

    // State, timer and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
        end
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;

endmodule

// File: tb/tb_steer_en.sv
// Directed bench for steer_en with the short (15-bit) qualification timer.
module tb_steer_en;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int tests;
    int fails;

    localparam int QUAL = 32768;

    steer_en #(.FAST_SIM(1'b1), .MIN_RIDER_WT(12'h200)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bit ok;
        rst_n = 1'b1; lft_ld = 12'h7FF; rght_ld = 12'h7FF;
        #2 rst_n = 1'b0;
        #2;
        tests++;
        if (en_steer !== 1'b0) begin fails++; $display("FAIL reset_en: got %b want 0", en_steer); end
        tests++;
        if (rider_off !== 1'b1) begin fails++; $display("FAIL reset_rider_off: got %b want 1", rider_off); end
        lft_ld = 12'h080; rght_ld = 12'h080;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        // Light load (sum 0x100) must never leave IDLE.
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (en_steer !== 1'b0 || rider_off !== 1'b1) ok = 1'b0;
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL light_load_idle: en=%b rider_off=%b want 0/1", en_steer, rider_off); end
        // One below the minimum weight.
        lft_ld = 12'h0FF; rght_ld = 12'h100;
        tick(5);
        tests++;
        if (rider_off !== 1'b1) begin fails++; $display("FAIL sum_1ff_idle: rider_off=%b want 1", rider_off); end
    endtask

    task automatic test_min_sum;
        // Exactly the minimum weight counts as a rider.
        lft_ld = 12'h100; rght_ld = 12'h100;
        tick(1);
        tests++;
        if (rider_off !== 1'b0 || en_steer !== 1'b0) begin
            fails++; $display("FAIL sum_200_wait: rider_off=%b en=%b want 0/0", rider_off, en_steer);
        end
        tick(4999);
    endtask

    task automatic test_lean;
        lft_ld = 12'h250; rght_ld = 12'h0B0;
        tick(2000);
        tests++;
        if (rider_off !== 1'b0 || en_steer !== 1'b0) begin
            fails++; $display("FAIL lean_wait: rider_off=%b en=%b want 0/0", rider_off, en_steer);
        end
    endtask

    // After the lean ends, the timer restarts; abs_diff equal to sum>>2
    // must not restart it again, so en rises 32768 edges after the lean.
    task automatic test_threshold_qual;
        lft_ld = 12'h1E0; rght_ld = 12'h120;
        tick(1000);
        tests++;
        if (en_steer !== 1'b0) begin fails++; $display("FAIL thresh_wait_en: got %b want 0", en_steer); end
        lft_ld = 12'h180; rght_ld = 12'h180;
        tick(32000 - 1000);
        tests++;
        if (en_steer !== 1'b0) begin fails++; $display("FAIL qual_32000: en=%b want 0", en_steer); end
        tick(QUAL - 1 - 32000);
        tests++;
        if (en_steer !== 1'b0) begin fails++; $display("FAIL qual_early: en=%b want 0", en_steer); end
        tick(1);
        tests++;
        if (en_steer !== 1'b1 || rider_off !== 1'b0) begin
            fails++; $display("FAIL qual_rise: en=%b rider_off=%b want 1/0", en_steer, rider_off);
        end
    endtask

    // Reset mid-cycle in STEER_EN, then full re-qualification at max loads.
    task automatic test_reset_steer;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            fails++; $display("FAIL async_reset: en=%b rider_off=%b want 0/1", en_steer, rider_off);
        end
        lft_ld = 12'hFFF; rght_ld = 12'hFFF;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        tests++;
        if (rider_off !== 1'b0 || en_steer !== 1'b0) begin
            fails++; $display("FAIL fff_wait: rider_off=%b en=%b want 0/0", rider_off, en_steer);
        end
        tick(QUAL - 1);
        tests++;
        if (en_steer !== 1'b0) begin fails++; $display("FAIL requal_early: en=%b want 0", en_steer); end
        tick(1);
        tests++;
        if (en_steer !== 1'b1) begin fails++; $display("FAIL requal_rise: en=%b want 1", en_steer); end
    endtask

    task automatic test_step_off;
        // Lean beyond 1/4 but inside 15/16 keeps steering.
        lft_ld = 12'h250; rght_ld = 12'h0B0;
        tick(3);
        tests++;
        if (en_steer !== 1'b1) begin fails++; $display("FAIL steer_lean_hold: en=%b want 1", en_steer); end
        // abs_diff exactly 15/16 of sum does not trip.
        lft_ld = 12'h2E8; rght_ld = 12'h018;
        tick(3);
        tests++;
        if (en_steer !== 1'b1) begin fails++; $display("FAIL steer_1516_equal: en=%b want 1", en_steer); end
        lft_ld = 12'h2F0; rght_ld = 12'h010;
        tick(1);
        tests++;
        if (en_steer !== 1'b0 || rider_off !== 1'b0) begin
            fails++; $display("FAIL step_off_wait: en=%b rider_off=%b want 0/0", en_steer, rider_off);
        end
        lft_ld = 12'h0F0; rght_ld = 12'h0F0;
        tick(1);
        tests++;
        if (rider_off !== 1'b1 || en_steer !== 1'b0) begin
            fails++; $display("FAIL step_off_idle: rider_off=%b en=%b want 1/0", rider_off, en_steer);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_min_sum();
        test_lean();
        test_threshold_qual();
        test_reset_steer();
        test_step_off();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
